// File: rtl/gamepad_scan_apb.sv
// Gamepad scanner with an APB3 register interface.
// Reads NUM_PADS NES/SNES-style serial pads that share one latch line and one
// clock line. Each frame is kept as a snapshot per pad, with button 0 in the MSB.
// Optional feature macro GAMEPAD_SCAN_IRQ_EN adds sticky PRESSED registers,
// IRQ_MASK and the IRQ output. Without it, those offsets read 0 and IRQ is 0.
module gamepad_scan_apb #(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 8,
  parameter int DIV_MAX  = 150
) (
  input  logic                PCLK,
  input  logic                PRESERN,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic                pad_latch,
  output logic                pad_clock,
  input  logic [NUM_PADS-1:0] pad_data,
  output logic                IRQ
);

  localparam int BIT_W = $clog2(NUM_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [9:0]       DIV_TC   = 10'(DIV_MAX);

  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

  state_t              r_state;
  logic [9:0]          r_divCount;
  logic [BIT_W-1:0]    r_bitIdx;
  logic                r_padLatch;
  logic                r_padClock;
  logic [7:0]          r_frameCnt;
  logic                r_scanEn;
  logic                r_pending;
  logic [NUM_BITS-1:0] r_shift [NUM_PADS];
  logic [NUM_BITS-1:0] r_snap  [NUM_PADS];

  logic        w_tick;
  logic        w_wrEn;
  logic        w_rdEn;
  logic [7:0]  w_addr;
  logic        w_ctrlWr;
  logic        w_trigger;
  logic        w_busy;
  logic [31:0] w_rdData;
  logic        w_unused;

  assign w_tick    = (r_divCount == DIV_TC);
  assign w_wrEn    = PSEL & PENABLE & PWRITE;
  assign w_rdEn    = PSEL & ~PENABLE & ~PWRITE;
  assign w_addr    = PADDR[7:0];
  assign w_ctrlWr  = w_wrEn && (w_addr == 8'h00);
  assign w_busy    = (r_state != IDLE);
  assign w_trigger = w_ctrlWr && PWDATA[1] && !w_busy;
  assign w_unused  = &{1'b0, PADDR[31:8], PWDATA};

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign pad_latch = r_padLatch;
  assign pad_clock = r_padClock;

  // Free-running divider; each wrap is one tick that paces the pad protocol.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      r_divCount <= '0;
    end else if (w_tick) begin
      r_divCount <= '0;
    end else begin
      r_divCount <= r_divCount + 10'd1;
    end
  end

  // Control bits. A one-shot trigger is only accepted while idle, and the frame it starts consumes it.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      r_scanEn  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_ctrlWr) begin
        r_scanEn <= PWDATA[0];
      end
      if (w_trigger) begin
        r_pending <= 1'b1;
      end else if (r_state == DONE) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Frame sequencer: latch, then NUM_BITS low/high clock pairs. Each bit is sampled at the end of its low phase.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      r_state    <= IDLE;
      r_padLatch <= 1'b0;
      r_padClock <= 1'b0;
      r_bitIdx   <= '0;
      r_frameCnt <= '0;
      for (int k = 0; k < NUM_PADS; k++) begin
        r_shift[k] <= '0;
        r_snap[k]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick && (r_scanEn || r_pending)) begin
            r_state    <= LATCH;
            r_padLatch <= 1'b1;
          end
        end
        LATCH: begin
          r_bitIdx <= '0;
          if (w_tick) begin
            r_state    <= LOW;
            r_padLatch <= 1'b0;
          end
        end
        LOW: begin
          if (w_tick) begin
            for (int k = 0; k < NUM_PADS; k++) begin
              r_shift[k] <= {r_shift[k][NUM_BITS-2:0], ~pad_data[k]};
            end
            r_state    <= HIGH;
            r_padClock <= 1'b1;
          end
        end
        HIGH: begin
          if (w_tick) begin
            r_padClock <= 1'b0;
            if (r_bitIdx < LAST_BIT) begin
              r_bitIdx <= r_bitIdx + BIT_ONE;
              r_state  <= LOW;
            end else begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          for (int k = 0; k < NUM_PADS; k++) begin
            r_snap[k] <= r_shift[k];
          end
          r_frameCnt <= r_frameCnt + 8'd1;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef GAMEPAD_SCAN_IRQ_EN
  logic [NUM_BITS-1:0] r_pressed [NUM_PADS];
  logic [NUM_PADS-1:0] r_irqMask;
  logic                w_irq;

  // Sticky press detection. When a clear and a new press hit the same bit in one cycle, the press wins.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      for (int k = 0; k < NUM_PADS; k++) begin
        r_pressed[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PADS; k++) begin
        r_pressed[k] <=
          (r_pressed[k] & ~((w_wrEn && (w_addr == 8'(24 + 4 * k))) ? PWDATA[NUM_BITS-1:0] : '0)) |
          ((r_state == DONE) ? (r_shift[k] & ~r_snap[k]) : '0);
      end
    end
  end

  // Interrupt enable per pad.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      r_irqMask <= '0;
    end else if (w_wrEn && (w_addr == 8'h28)) begin
      r_irqMask <= PWDATA[NUM_PADS-1:0];
    end
  end

  // Level interrupt: raised by any enabled pad with at least one sticky press.
  always_comb begin
    w_irq = 1'b0;
    for (int k = 0; k < NUM_PADS; k++) begin
      w_irq = w_irq | (r_irqMask[k] & (|r_pressed[k]));
    end
  end

  assign IRQ = w_irq;
`else
  assign IRQ = 1'b0;
`endif

  // Read data mux. Unmapped offsets and nonexistent pads read as 0.
  always_comb begin
    w_rdData = '0;
    if (w_addr == 8'h00) begin
      w_rdData[0] = r_scanEn;
    end
    if (w_addr == 8'h04) begin
      w_rdData[0]    = w_busy;
      w_rdData[15:8] = r_frameCnt;
    end
    for (int k = 0; k < NUM_PADS; k++) begin
      if (w_addr == 8'(8 + 4 * k)) begin
        w_rdData[NUM_BITS-1:0] = r_snap[k];
      end
`ifdef GAMEPAD_SCAN_IRQ_EN
      if (w_addr == 8'(24 + 4 * k)) begin
        w_rdData[NUM_BITS-1:0] = r_pressed[k];
      end
`endif
    end
`ifdef GAMEPAD_SCAN_IRQ_EN
    if (w_addr == 8'h28) begin
      w_rdData[NUM_PADS-1:0] = r_irqMask;
    end
`endif
  end

  // PRDATA is captured during the APB setup phase and held until the next read.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      PRDATA <= '0;
    end else if (w_rdEn) begin
      PRDATA <= w_rdData;
    end
  end

endmodule

// File: tb/tb_gamepad_scan_apb.sv
// Self-checking bench for gamepad_scan_apb (NUM_PADS=2, NUM_BITS=8, DIV_MAX=3).
// The pad model latches its button state on pad_latch and then presents one
// button per pad_clock rising edge, active-low. Expected register contents
// come from a frame-level model: each snapshot holds button i at bit NUM_BITS-1-i.
module tb_gamepad_scan_apb;

  localparam int NUM_PADS = 2;
  localparam int NUM_BITS = 8;
  localparam int DIV_MAX  = 3;
  localparam int TICK     = DIV_MAX + 1;
`ifdef GAMEPAD_SCAN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic                PCLK;
  logic                PRESERN;
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [31:0]         PADDR;
  logic [31:0]         PWDATA;
  logic [31:0]         PRDATA;
  logic                PREADY;
  logic                PSLVERR;
  logic                pad_latch;
  logic                pad_clock;
  logic [NUM_PADS-1:0] pad_data;
  logic                IRQ;

  int checks = 0;
  int errors = 0;

  // Button state per pad: bit i set means button i is held down.
  logic [NUM_BITS-1:0] btn [NUM_PADS];
  logic [NUM_BITS-1:0] latchedBtn [NUM_PADS] = '{default: '0};
  int padIdx = 0;

  // Reference model state.
  logic [NUM_BITS-1:0] snapExp    [NUM_PADS];
  logic [NUM_BITS-1:0] pressedExp [NUM_PADS];
  logic [NUM_PADS-1:0] maskExp;
  logic [7:0]          frameExp;

  // Pad-line activity counters, sampled at the falling edge of PCLK.
  int latchCycles = 0;
  int clkHighCycles = 0;
  int clkPulses = 0;
  int latchRises = 0;
  logic prevClk = 1'b0;
  logic prevLatch = 1'b0;

  gamepad_scan_apb #(
    .NUM_PADS(NUM_PADS),
    .NUM_BITS(NUM_BITS),
    .DIV_MAX (DIV_MAX)
  ) dut (
    .PCLK     (PCLK),
    .PRESERN  (PRESERN),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .pad_latch(pad_latch),
    .pad_clock(pad_clock),
    .pad_data (pad_data),
    .IRQ      (IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Pad behaviour: the latch captures the buttons and restarts at button 0. Each clock rise moves to the next button.
  always @(posedge pad_latch or posedge pad_clock) begin
    if (pad_latch) begin
      padIdx = 0;
      for (int k = 0; k < NUM_PADS; k++) latchedBtn[k] = btn[k];
    end else begin
      padIdx = padIdx + 1;
    end
  end

  // Serial output lines. A held button drives low; past the last button the line idles high.
  always_comb begin
    pad_data = '1;
    for (int k = 0; k < NUM_PADS; k++) begin
      if (padIdx < NUM_BITS) pad_data[k] = ~latchedBtn[k][padIdx];
    end
  end

  // Measures latch width, clock-high width and number of clock pulses.
  always @(negedge PCLK) begin
    if (pad_latch) latchCycles = latchCycles + 1;
    if (pad_clock) clkHighCycles = clkHighCycles + 1;
    if (pad_clock && !prevClk) clkPulses = clkPulses + 1;
    if (pad_latch && !prevLatch) latchRises = latchRises + 1;
    prevClk = pad_clock;
    prevLatch = pad_latch;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic logic [NUM_BITS-1:0] buttonsToSnap(input logic [NUM_BITS-1:0] b);
    logic [NUM_BITS-1:0] s;
    for (int i = 0; i < NUM_BITS; i++) s[NUM_BITS-1-i] = b[i];
    return s;
  endfunction

  // One completed frame in model terms.
  task automatic modelFrame();
    logic [NUM_BITS-1:0] s;
    for (int k = 0; k < NUM_PADS; k++) begin
      s = buttonsToSnap(btn[k]);
      pressedExp[k] = pressedExp[k] | (s & ~snapExp[k]);
      snapExp[k] = s;
    end
    frameExp = frameExp + 8'd1;
  endtask

  task automatic modelReset();
    for (int k = 0; k < NUM_PADS; k++) begin
      snapExp[k] = '0;
      pressedExp[k] = '0;
    end
    maskExp = '0;
    frameExp = '0;
  endtask

  function automatic logic [31:0] expPressed(input int k);
    return IRQ_EN ? 32'(pressedExp[k]) : 32'h0;
  endfunction

  function automatic logic expIrq();
    logic r;
    r = 1'b0;
    for (int k = 0; k < NUM_PADS; k++) r = r | (maskExp[k] & (|pressedExp[k]));
    return IRQ_EN ? r : 1'b0;
  endfunction

  task automatic waitIdle(input string tag);
    logic [31:0] d;
    d = '1;
    repeat (2 * TICK) @(negedge PCLK);
    for (int i = 0; i < 200; i++) begin
      apbRead(32'h04, d);
      if (!d[0]) break;
    end
    checkOutput(tag, 32'(d[0]), 32'h0);
  endtask

  task automatic waitFrameCount(input logic [7:0] target);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      apbRead(32'h04, d);
      if (d[15:8] == target) break;
    end
    checkOutput("frame_sync", 32'(d[15:8]), 32'(target));
  endtask

  task automatic checkRegs(input string tag, input bit checkFrame);
    logic [31:0] d;
    for (int k = 0; k < NUM_PADS; k++) begin
      apbRead(32'(8 + 4 * k), d);
      checkOutput($sformatf("%s_snap%0d", tag, k), d, 32'(snapExp[k]));
      apbRead(32'(24 + 4 * k), d);
      checkOutput($sformatf("%s_pressed%0d", tag, k), d, expPressed(k));
    end
    apbRead(32'h28, d);
    checkOutput({tag, "_mask"}, d, IRQ_EN ? 32'(maskExp) : 32'h0);
    checkOutput({tag, "_irq"}, 32'(IRQ), 32'(expIrq()));
    if (checkFrame) begin
      apbRead(32'h04, d);
      checkOutput({tag, "_status"}, d, {16'h0, frameExp, 8'h0});
    end
  endtask

  // One randomized one-shot frame, with optional random W1C and mask writes beforehand.
  task automatic applyStimulus(input int n);
    logic [31:0] w;
    for (int k = 0; k < NUM_PADS; k++) btn[k] = NUM_BITS'($urandom_range(0, (1 << NUM_BITS) - 1));
    if ($urandom_range(0, 2) == 0) begin
      int k;
      k = $urandom_range(0, NUM_PADS - 1);
      w = 32'($urandom_range(0, (1 << NUM_BITS) - 1));
      apbWrite(32'(24 + 4 * k), w);
      pressedExp[k] = pressedExp[k] & ~w[NUM_BITS-1:0];
    end
    maskExp = NUM_PADS'($urandom_range(0, (1 << NUM_PADS) - 1));
    apbWrite(32'h28, 32'(maskExp));
    apbWrite(32'h00, 32'h2);
    waitIdle($sformatf("rand%0d_idle", n));
    modelFrame();
    checkRegs($sformatf("rand%0d", n), 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    int base, baseH, baseL, baseR;
    logic [7:0] c0;

    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    for (int k = 0; k < NUM_PADS; k++) btn[k] = '0;
    modelReset();
    PRESERN = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b0;

    // Reset state
    checkOutput("rst_latch", 32'(pad_latch), 32'h0);
    checkOutput("rst_clock", 32'(pad_clock), 32'h0);
    apbRead(32'h00, d);
    checkOutput("rst_ctrl", d, 32'h0);
    checkRegs("rst", 1'b1);

    // Single triggered frame, pad0 drives 0111_1110 MSB first
    btn[0] = NUM_BITS'(8'h81);
    btn[1] = '0;
    baseL = latchCycles; baseH = clkHighCycles; base = clkPulses;
    apbWrite(32'h00, 32'h2);
    waitIdle("basic_idle");
    modelFrame();
    checkOutput("basic_latch_width", 32'(latchCycles - baseL), 32'(TICK));
    checkOutput("basic_clk_pulses", 32'(clkPulses - base), 32'(NUM_BITS));
    checkOutput("basic_clk_high", 32'(clkHighCycles - baseH), 32'(NUM_BITS * TICK));
    apbRead(32'h08, d);
    checkOutput("basic_snap0", d, 32'h81);
    checkRegs("basic", 1'b1);

    // Randomized frames
    for (int n = 0; n < 16; n++) applyStimulus(n);

    // Decode corners: upper address bits are ignored, unmapped offsets and absent pads read 0, RO writes are ignored
    apbRead(32'h108, d);
    checkOutput("alias_snap0", d, 32'(snapExp[0]));
    apbRead(32'h10, d);
    checkOutput("snap2_absent", d, 32'h0);
    apbRead(32'h20, d);
    checkOutput("pressed2_absent", d, 32'h0);
    apbRead(32'h2C, d);
    checkOutput("unmapped_2c", d, 32'h0);
    apbWrite(32'h08, 32'hFF);
    apbWrite(32'h04, 32'hFFFF);
    checkRegs("ro_write", 1'b1);

    // W1C in the same cycle as DONE sets the bit: the set wins
    btn[0] = '0;
    apbWrite(32'h00, 32'h2);
    waitIdle("w1c_pre_idle");
    modelFrame();
    btn[0] = NUM_BITS'(8'h0F);
    base = clkPulses;
    apbWrite(32'h00, 32'h2);
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      if (clkPulses - base >= NUM_BITS) break;
    end
    checkOutput("w1c_pulses", 32'(clkPulses - base), 32'(NUM_BITS));
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 32'h18; PWDATA = 32'hFF;
    for (int i = 0; i < 20; i++) begin
      if (!pad_clock) break;
      @(negedge PCLK);
    end
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    pressedExp[0] = '0;
    modelFrame();
    waitIdle("w1c_idle");
    checkRegs("w1c_race", 1'b1);

    // Button 3 on pad1 goes from released to pressed across continuous frames
    apbWrite(32'h18, 32'hFF);
    apbWrite(32'h1C, 32'hFF);
    pressedExp[0] = '0;
    pressedExp[1] = '0;
    for (int k = 0; k < NUM_PADS; k++) btn[k] = '0;
    maskExp = NUM_PADS'(2);
    apbWrite(32'h28, 32'h2);
    apbRead(32'h04, d);
    c0 = d[15:8];
    apbWrite(32'h00, 32'h1);
    waitFrameCount(c0 + 8'd1);
    modelFrame();
    btn[1] = NUM_BITS'(8'h08);
    waitFrameCount(c0 + 8'd3);
    apbWrite(32'h00, 32'h0);
    waitIdle("cont_idle");
    modelFrame();
    checkRegs("cont", 1'b0);
    apbRead(32'h1C, d);
    checkOutput("cont_pressed1", d, IRQ_EN ? 32'h10 : 32'h0);
    apbWrite(32'h1C, 32'h10);
    pressedExp[1] = pressedExp[1] & ~NUM_BITS'(8'h10);
    checkRegs("cont_clr", 1'b0);

    // Reset during the 5th high phase aborts the frame
    btn[0] = NUM_BITS'(8'hFF);
    base = clkPulses;
    apbWrite(32'h00, 32'h2);
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      if (clkPulses - base >= 5) break;
    end
    checkOutput("abort_clk_high", 32'(pad_clock), 32'h1);
    PRESERN = 1'b1;
    #1;
    checkOutput("abort_clock", 32'(pad_clock), 32'h0);
    checkOutput("abort_latch", 32'(pad_latch), 32'h0);
    modelReset();
    repeat (2) @(negedge PCLK);
    PRESERN = 1'b0;
    apbRead(32'h00, d);
    checkOutput("abort_ctrl", d, 32'h0);
    checkRegs("abort", 1'b1);

    // A trigger written while busy is dropped, not queued
    btn[0] = NUM_BITS'($urandom_range(1, (1 << NUM_BITS) - 1));
    btn[1] = NUM_BITS'($urandom_range(0, (1 << NUM_BITS) - 1));
    apbWrite(32'h00, 32'h2);
    d = '0;
    for (int i = 0; i < 20; i++) begin
      apbRead(32'h04, d);
      if (d[0]) break;
    end
    checkOutput("busy_seen", 32'(d[0]), 32'h1);
    apbWrite(32'h00, 32'h2);
    waitIdle("trig_busy_idle");
    modelFrame();
    repeat (3 * TICK * (2 * NUM_BITS + 2)) @(negedge PCLK);
    checkRegs("trig_busy", 1'b1);

    // 256 continuous frames bring the frame counter back to the same value
    baseR = latchRises;
    apbWrite(32'h00, 32'h1);
    for (int i = 0; i < 30000; i++) begin
      @(negedge PCLK);
      if (latchRises - baseR >= 256) break;
    end
    apbWrite(32'h00, 32'h0);
    waitIdle("wrap_idle");
    checkOutput("wrap_frames", 32'(latchRises - baseR), 32'd256);
    for (int i = 0; i < 256; i++) modelFrame();
    checkRegs("wrap", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
